// File: rtl/tpu_pkg.sv
// Shared TPU constants and types used by the weight and result memories.
package tpu_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LANES = 4;

    // Entry address; arithmetic on it wraps modulo DEPTH.
    typedef logic [2:0] addr_t;

    typedef enum logic {
        IDLE,
        STREAM
    } stream_state_t;

endpackage

// File: rtl/result_ram.sv
// Result storage: multi-lane write port and one asynchronous read port.
// A read sampled on the same edge as a write sees the old contents.
module result_ram
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = tpu_pkg::DEPTH,
    parameter int unsigned WIDTH = tpu_pkg::WIDTH,
    parameter int unsigned LANES = tpu_pkg::LANES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  addr_t                    waddr_i,
    input  logic [LANES*WIDTH-1:0]   wdata_i,
    input  addr_t                    raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Clear on reset; otherwise write LANES consecutive entries, wrapping past the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int k = 0; k < LANES; k++) begin
                mem_q[waddr_i + addr_t'(k)] <= wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/result_streamer.sv
// Captures four MMU results per store and streams a run of entries
// off-chip, one byte per valid/ready handshake.
module result_streamer
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = tpu_pkg::DEPTH,
    parameter int unsigned WIDTH = tpu_pkg::WIDTH,
    parameter int unsigned LANES = tpu_pkg::LANES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             store_res,
    input  logic [2:0]       store_addr,
    input  logic [WIDTH-1:0] res1,
    input  logic [WIDTH-1:0] res2,
    input  logic [WIDTH-1:0] res3,
    input  logic [WIDTH-1:0] res4,
    input  logic             start_read,
    input  logic [2:0]       read_base,
    input  logic [3:0]       read_len,
    input  logic             out_ready,
    output logic [WIDTH-1:0] uo_out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    stream_state_t    state_q;
    addr_t            ptr_q;
    logic [3:0]       rem_q;
    logic [WIDTH-1:0] uo_q;
    logic             valid_q;
    logic             done_q;

    addr_t            rd_addr;
    logic [WIDTH-1:0] rd_data;

    // In IDLE the first byte comes straight from read_base; afterwards from the pointer.
    assign rd_addr = (state_q == IDLE) ? read_base : ptr_q;

    result_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (store_res),
        .waddr_i (store_addr),
        .wdata_i ({res4, res3, res2, res1}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Stream FSM with registered byte, valid and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            uo_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_read) begin
                        if (read_len != 4'd0) begin
                            uo_q    <= rd_data;
                            valid_q <= 1'b1;
                            ptr_q   <= read_base + 3'd1;
                            rem_q   <= read_len - 4'd1;
                            state_q <= STREAM;
                        end else begin
                            // Empty request completes immediately.
                            done_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (rem_q == 4'd0) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            uo_q  <= rd_data;
                            ptr_q <= ptr_q + 3'd1;
                            rem_q <= rem_q - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign uo_out    = uo_q;
    assign out_valid = valid_q;
    assign done      = done_q;
    assign busy      = (state_q == STREAM);

endmodule

// File: tb/tb_result_streamer.sv
// Scoreboard bench for result_streamer: stimulus pushes expected bytes from a
// plain array model of the memory; a negedge monitor pops them on each handshake.
module tb_result_streamer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       store_res = 1'b0;
    logic [2:0] store_addr = '0;
    logic [7:0] res1 = '0, res2 = '0, res3 = '0, res4 = '0;
    logic       start_read = 1'b0;
    logic [2:0] read_base = '0;
    logic [3:0] read_len = '0;
    logic       out_ready = 1'b1;
    logic [7:0] uo_out;
    logic       out_valid, busy, done;

    result_streamer dut (
        .clk        (clk),
        .reset      (reset),
        .store_res  (store_res),
        .store_addr (store_addr),
        .res1       (res1),
        .res2       (res2),
        .res3       (res3),
        .res4       (res4),
        .start_read (start_read),
        .read_base  (read_base),
        .read_len   (read_len),
        .out_ready  (out_ready),
        .uo_out     (uo_out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    logic [7:0] model [8];
    logic [7:0] exp_q [$];
    logic [7:0] exp_b;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled mid-cycle, so out_ready already holds its value for the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", uo_out, $time);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("stream_byte", int'(uo_out), int'(exp_b));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input int addr, input int a, input int b, input int c, input int d);
        store_res  = 1'b1;
        store_addr = 3'(addr);
        res1 = 8'(a); res2 = 8'(b); res3 = 8'(c); res4 = 8'(d);
        model[(addr + 0) % 8] = 8'(a);
        model[(addr + 1) % 8] = 8'(b);
        model[(addr + 2) % 8] = 8'(c);
        model[(addr + 3) % 8] = 8'(d);
        step();
        store_res = 1'b0;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready pattern 1,0,0,1,1
    task automatic run_stream(input int base, input int len, input int mode,
                              input bit ignore_req, input bit coll);
        int before_done, before_hs, cyc;
        logic pat [5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        before_done = done_cnt;
        before_hs   = hs_cnt;
        for (int i = 0; i < len; i++) exp_q.push_back(model[(base + i) % 8]);
        read_base  = 3'(base);
        read_len   = 4'(len);
        start_read = 1'b1;
        out_ready  = 1'b1;
        step();
        start_read = 1'b0;
        if (len == 0) begin
            check("len0_done", int'(done), 1);
            check("len0_valid", int'(out_valid), 0);
        end else begin
            check("start_busy", int'(busy), 1);
            check("start_valid", int'(out_valid), 1);
        end
        cyc = 0;
        while (busy && cyc < 100) begin
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (cyc < 5) ? pat[cyc] : 1'b1;
                default: out_ready = 1'b1;
            endcase
            if (ignore_req && cyc == 0) begin
                start_read = 1'b1;
                read_base  = 3'd5;
                read_len   = 4'd8;
            end
            if (coll && cyc == 0) begin
                // Entry 1 is read on this same edge; stream must see the old byte.
                store_res  = 1'b1;
                store_addr = 3'd1;
                res1 = 8'hAA; res2 = 8'hBB; res3 = 8'hCC; res4 = 8'hDD;
                model[1] = 8'hAA; model[2] = 8'hBB; model[3] = 8'hCC; model[4] = 8'hDD;
            end
            step();
            start_read = 1'b0;
            store_res  = 1'b0;
            cyc++;
            if (mode == 2 && busy && !out_ready) check("hold_valid", int'(out_valid), 1);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got busy=1 expected busy=0 at %0t", $time);
        end
        out_ready = 1'b1;
        if (len != 0) begin
            check("end_done", int'(done), 1);
            check("end_valid", int'(out_valid), 0);
        end
        step();
        check("done_single", int'(done), 0);
        check("done_pulses", done_cnt - before_done, 1);
        check("handshakes", hs_cnt - before_hs, len);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        repeat (3) step();
        check("rst_uo_out", int'(uo_out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        step();

        do_store(0, 'h11, 'h22, 'h33, 'h44);
        run_stream(0, 4, 0, 1'b0, 1'b0);

        do_store(6, 'h01, 'h02, 'h03, 'h04);
        run_stream(6, 4, 0, 1'b0, 1'b0);

        run_stream(1, 3, 2, 1'b0, 1'b0);

        run_stream(0, 2, 0, 1'b0, 1'b1);
        run_stream(1, 3, 0, 1'b1, 1'b0);

        run_stream(4, 0, 0, 1'b0, 1'b0);
        run_stream(3, 8, 1, 1'b0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_store(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)));
            end else begin
                run_stream(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
                           int'($urandom_range(0, 2)), 1'b0, 1'b0);
            end
        end

        // Reset after two of four bytes have been accepted.
        begin
            int before_done;
            do_store(0, 'h5A, 'h6B, 'h7C, 'h8D);
            before_done = done_cnt;
            for (int i = 0; i < 4; i++) exp_q.push_back(model[i]);
            read_base  = 3'd0;
            read_len   = 4'd4;
            start_read = 1'b1;
            step();
            start_read = 1'b0;
            out_ready  = 1'b1;
            step();
            step();
            reset     = 1'b1;
            out_ready = 1'b0;
            step();
            check("midrst_valid", int'(out_valid), 0);
            check("midrst_busy", int'(busy), 0);
            check("midrst_done", int'(done), 0);
            exp_q.delete();
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
            reset     = 1'b0;
            out_ready = 1'b1;
            step();
            check("midrst_no_done", done_cnt - before_done, 0);
            run_stream(0, 1, 0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_streamer.md
# result_streamer

Output-side counterpart of the weight memory: captures the four 8-bit results the MMU produces in parallel, holds them in an 8-entry result memory, and streams a selected run of entries off-chip one byte per handshake on `uo_out`. It sits between the MMU accumulator outputs and the chip output pins, and is driven by the same control unit that sequences weight loading.

## Interface
Parameters:
- `DEPTH`, 8: result memory entries. Must be a power of two.
- `WIDTH`, 8: bits per entry.
- `LANES`, 4: results captured per store.

Ports:
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `store_res`, input, 1: capture `res1`..`res4` this cycle.
- `store_addr`, input, 3: base entry for the store.
- `res1`..`res4`, input, 8 each: MMU results for lanes 0..3.
- `start_read`, input, 1: request a stream. Accepted only in IDLE.
- `read_base`, input, 3: first entry to stream.
- `read_len`, input, 4: number of entries to stream, 0..8.
- `out_ready`, input, 1: consumer accepts `uo_out` this cycle.
- `uo_out`, output, 8: current streamed byte (registered).
- `out_valid`, output, 1: `uo_out` holds a byte not yet accepted.
- `busy`, output, 1: FSM is in STREAM.
- `done`, output, 1: one-cycle pulse after a stream completes.

## Operation
- Reset: all memory entries, `uo_out`, `out_valid`, `done`, pointer and counter are 0. FSM goes to IDLE.
- Store: when `store_res` is high, `mem[(store_addr+k) mod 8] <= res(k+1)` for k = 0..3 in one cycle. A store is accepted in any FSM state.
- FSM state IDLE:
  - If `start_read` and `read_len` != 0: `uo_out <= mem[read_base]`, `out_valid <= 1`, `ptr <= read_base+1`, `remaining <= read_len-1`. Go to STREAM.
  - If `start_read` and `read_len` == 0: `done <= 1` next cycle. Stay in IDLE with no `out_valid`.
- FSM state STREAM, on each cycle where `out_ready` is high:
  - If `remaining` == 0: `out_valid <= 0`, `done <= 1`, go to IDLE.
  - Otherwise: `uo_out <= mem[ptr]`, `ptr <= ptr+1`, `remaining <= remaining-1`.
- FSM state STREAM, when `out_ready` is low: `uo_out`, `out_valid`, `ptr` and `remaining` all hold.
- `start_read` is ignored while in STREAM.
- Address arithmetic: `ptr` and the store addresses are 3 bits and wrap modulo 8 (entry 7 is followed by entry 0).
- Store/read collision: a store and a stream read of the same entry on the same edge gives the read the pre-edge (old) contents.
- After a stream, `uo_out` keeps the last byte while `out_valid` is 0.
- `done` is 0 in every cycle where it is not explicitly pulsed.
- `busy` = (state == STREAM).

## Timing
- `start_read` accepted at edge T: first byte is valid after T, so latency is 1 cycle.
- With `out_ready` held high, byte k is presented in cycle T+1+k.
- The final handshake occurs at edge T+len. `done` and `out_valid` = 0 appear after that edge, and `busy` drops at the same time.
- A new `start_read` is accepted in the cycle `done` is high (FSM is already IDLE). Back-to-back streams have a 1-cycle gap.
- Throughput: one byte per cycle while `out_ready` is high.
- Reset mid-stream: returns to IDLE at the next edge, with no `done` pulse and memory cleared.

## Structure
- Shared package `tpu_pkg` holds:
  - `WIDTH`, `DEPTH` and `LANES` constants.
  - The `stream_state_t` enum (IDLE, STREAM).
  - An `addr_t` 3-bit typedef, shared with the weight memory.
- One natural sub-module, `result_ram`: 8x8 storage with a 4-lane write port and 1 read port.
- The FSM, pointer and output register stay in `result_streamer`.

## Test plan
- Reset, then store `res` = 11,22,33,44 at `store_addr` 0. Stream with base 0, len 4, `out_ready` high: `uo_out` = 11,22,33,44 on consecutive cycles, `done` pulses once, `busy` falls.
- Wrap-around: store 01,02,03,04 at `store_addr` 6, so entries 6,7,0,1 are written. Stream base 6, len 4: output is 01,02,03,04.
- Backpressure: len 3 with `out_ready` toggling 1,0,0,1,1. Each byte is held while `out_ready` is 0, and exactly 3 bytes are delivered.
- Collision and ignored request:
  - Store AA to entry 1 in the same cycle it is being read: the stream outputs the old value.
  - `start_read` during STREAM is ignored.
- `read_len` 0 gives a `done` pulse only, with no `out_valid`. `read_len` 8 streams all 8 entries.
- Reset asserted after 2 of 4 bytes: `out_valid` 0, no `done`, and a later stream of entry 0 reads 00.
